// File: rtl/switch_led_sequencer.sv
// Debounces four board switches and drives LEDs 1-3 in DIRECT, TOGGLE or CHASE mode.
// Define SWITCH_LED_SYNC_EN to add a 2-flop synchronizer on every raw switch input.
module switch_led_sequencer #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CHASE_TICKS    = 6250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3,
  output logic o_LED_4
);

  localparam int CNT_W = ($clog2(DEBOUNCE_LIMIT) < 1) ? 1 : $clog2(DEBOUNCE_LIMIT);
  localparam int TMR_W = ($clog2(CHASE_TICKS) < 1) ? 1 : $clog2(CHASE_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(CHASE_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT,
    MODE_TOGGLE,
    MODE_CHASE
  } mode_t;

  logic [3:0] raw_sw;
  logic [3:0] sampled;
  logic [3:0] s_reg;
  logic [3:0] stable;
  logic [3:0] stable_prev;
  logic [3:0] press;
  logic [CNT_W-1:0] cnt [4];

  mode_t      state;
  mode_t      state_next;
  logic [2:0] latch;
  logic [2:0] latch_next;
  logic [2:0] pattern;
  logic [2:0] pattern_next;
  logic       dir_down;
  logic       dir_down_next;
  logic       dir_eff;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic [3:0] led_q;
  logic [3:0] led_next;

  assign raw_sw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

`ifdef SWITCH_LED_SYNC_EN
  logic [3:0] sync_1;
  logic [3:0] sync_2;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw_sw;
      sync_2 <= sync_1;
    end
  end

  assign sampled = sync_2;
`else
  assign sampled = raw_sw;
`endif

  // The counter only runs while the sampled level disagrees with the accepted one,
  // so any disagreement shorter than the limit falls back to zero and is forgotten.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      s_reg       <= '0;
      stable      <= '0;
      stable_prev <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s_reg       <= sampled;
      stable_prev <= stable;
      for (int i = 0; i < 4; i++) begin
        if (s_reg[i] != stable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            stable[i] <= s_reg[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = stable & ~stable_prev;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= MODE_DIRECT;
      latch    <= '0;
      pattern  <= 3'b001;
      dir_down <= 1'b0;
      timer    <= '0;
      led_q    <= '0;
    end else begin
      state    <= state_next;
      latch    <= latch_next;
      pattern  <= pattern_next;
      dir_down <= dir_down_next;
      timer    <= timer_next;
      led_q    <= led_next;
    end
  end

  // A mode-step press swallows every other press in the same cycle.
  always_comb begin
    state_next    = state;
    latch_next    = latch;
    pattern_next  = pattern;
    dir_down_next = dir_down;
    timer_next    = timer;
    led_next      = '0;
    dir_eff       = dir_down;

    case (state)
      MODE_DIRECT: begin
        led_next = {1'b0, stable[2:0]};
        if (press[3]) begin
          state_next = MODE_TOGGLE;
          latch_next = '0;
        end
      end

      MODE_TOGGLE: begin
        led_next = {1'b1, latch};
        if (press[3]) begin
          state_next    = MODE_CHASE;
          pattern_next  = 3'b001;
          timer_next    = '0;
          dir_down_next = 1'b0;
        end else begin
          latch_next = latch ^ press[2:0];
        end
      end

      MODE_CHASE: begin
        led_next = {1'b0, pattern};
        if (press[3]) begin
          state_next = MODE_DIRECT;
        end else begin
          // A direction flip on the terminal cycle already steers this step.
          dir_eff       = dir_down ^ press[0];
          dir_down_next = dir_eff;
          if (timer == TMR_MAX) begin
            timer_next   = '0;
            pattern_next = dir_eff ? {pattern[0], pattern[2:1]}
                                   : {pattern[1:0], pattern[2]};
          end else begin
            timer_next = timer + 1'b1;
          end
        end
      end

      default: begin
        state_next = MODE_DIRECT;
      end
    endcase
  end

  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_switch_led_sequencer.sv
// Directed bench for switch_led_sequencer with DEBOUNCE_LIMIT=4, CHASE_TICKS=8.
// Expected latencies follow SWITCH_LED_SYNC_EN when the bench is built with it.
module tb_switch_led_sequencer;

  localparam int DB = 4;
  localparam int CT = 8;
`ifdef SWITCH_LED_SYNC_EN
  localparam int LAT = DB + 4;
`else
  localparam int LAT = DB + 2;
`endif
  localparam int D = LAT - 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:1] sw = '0;
  logic       led_1, led_2, led_3, led_4;
  logic [3:0] leds;
  int         compared = 0;
  int         mismatched = 0;

  assign leds = {led_4, led_3, led_2, led_1};

  switch_led_sequencer #(
    .DEBOUNCE_LIMIT(DB),
    .CHASE_TICKS   (CT)
  ) dut (
    .i_Clk     (clk),
    .i_Reset   (reset),
    .i_Switch_1(sw[1]),
    .i_Switch_2(sw[2]),
    .i_Switch_3(sw[3]),
    .i_Switch_4(sw[4]),
    .o_LED_1   (led_1),
    .o_LED_2   (led_2),
    .o_LED_3   (led_3),
    .o_LED_4   (led_4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic level);
    sw[idx] = level;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic press_switch(input int idx);
    applyStimulus(idx, 1'b1);
    repeat (10) tick();
    applyStimulus(idx, 1'b0);
    repeat (10) tick();
  endtask

  // Chase pattern seen on LED[3:1], indexed by edges since the mode-step press began.
  function automatic logic [2:0] chase_expect(input int r);
    if (r <= 14)      return 3'b001;
    else if (r <= 22) return 3'b010;
    else if (r <= 30) return 3'b100;
    else if (r <= 38) return 3'b010;
    else if (r <= 46) return 3'b001;
    else if (r <= 54) return 3'b010;
    else              return 3'b100;
  endfunction

  initial begin
    // Reset with all switches open
    repeat (3) tick();
    checkOutput("reset_leds", leds, 4'b0000);
    reset = 1'b0;
    tick();
    checkOutput("post_reset_leds", leds, 4'b0000);

    // Short glitch on switch 2 must be rejected
    applyStimulus(2, 1'b1);
    repeat (3) tick();
    applyStimulus(2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("glitch_led2", leds, 4'b0000);
    end

    // Steady hold: LED_2 rises exactly LAT edges in
    applyStimulus(2, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e < LAT) checkOutput("hold_led2_low", leds, 4'b0000);
      else         checkOutput("hold_led2_high", leds, 4'b0010);
    end
    applyStimulus(2, 1'b0);
    repeat (10) tick();
    checkOutput("release_led2", leds, 4'b0000);

    // TOGGLE mode latches
    press_switch(4);
    checkOutput("toggle_enter", leds, 4'b1000);
    press_switch(1);
    checkOutput("toggle_led1_on", leds, 4'b1001);
    press_switch(1);
    checkOutput("toggle_led1_off", leds, 4'b1000);
    press_switch(3);
    checkOutput("toggle_led3_on", leds, 4'b1100);
    press_switch(1);
    checkOutput("toggle_latch_101", leds, 4'b1101);

    // Reset mid-operation returns to DIRECT
    reset = 1'b1;
    tick();
    checkOutput("midrun_reset", leds, 4'b0000);
    reset = 1'b0;
    applyStimulus(1, 1'b1);
    repeat (10) tick();
    checkOutput("direct_after_reset_hold", leds, 4'b0001);
    applyStimulus(1, 1'b0);
    repeat (10) tick();
    checkOutput("direct_after_reset_release", leds, 4'b0000);

    // CHASE: run the pattern, reverse mid-step, then reverse on a terminal cycle
    press_switch(4);
    checkOutput("toggle_again", leds, 4'b1000);
    applyStimulus(4, 1'b1);
    for (int e = 1; e <= 56 + D; e++) begin
      int r;
      tick();
      r = e - D;
      if (r == 6) checkOutput("chase_entry_still_toggle", leds, 4'b1000);
      if (r >= 7) checkOutput("chase_step", leds, {1'b0, chase_expect(r)});
      if (e == 8)  applyStimulus(4, 1'b0);
      if (e == 20) applyStimulus(1, 1'b1);
      if (e == 28) applyStimulus(1, 1'b0);
      if (e == 40) applyStimulus(1, 1'b1);
      if (e == 48) applyStimulus(1, 1'b0);
    end

    // Simultaneous mode-step and switch-2 press in TOGGLE
    press_switch(4);
    checkOutput("chase_to_direct", leds, 4'b0000);
    press_switch(4);
    checkOutput("direct_to_toggle", leds, 4'b1000);
    applyStimulus(4, 1'b1);
    applyStimulus(2, 1'b1);
    repeat (LAT) tick();
    checkOutput("simul_press_edge", leds, 4'b1000);
    tick();
    checkOutput("simul_press_chase", leds, 4'b0001);
    applyStimulus(4, 1'b0);
    applyStimulus(2, 1'b0);
    repeat (10) tick();
    checkOutput("simul_chase_step", leds, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
